approx_prod_acc: RTL
====================

# approx_prod_acc

Downstream accumulation stage for the 16x16 approximate logarithmic multiplier. Each beat carries one 32-bit signed product in the multiplier's output encoding: negatives are ones'-complement, and zero is all-zero. The block converts each product to two's complement, sums LEN consecutive products into a wide accumulator, and hands the sum downstream through a registered valid/ready port. A pending result does not stall accumulation of the next frame until that frame's final beat arrives.

## Interface
- LEN, default 16: products per frame; 2 <= LEN <= 2^(ACC_W-32).
- ACC_W, default 40: accumulator and result width, signed.
- FRM_W, default 8: width of the frame counter.
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- clear, input, 1: synchronous abort of the current partial frame.
- in_valid, input, 1: product beat valid.
- in_ready, output, 1: beat accepted when in_valid & in_ready.
- p_i, input, 32: product from the multiplier, ones'-complement-negative encoding.
- out_valid, output, 1: result valid.
- out_ready, input, 1: result consumed when out_valid & out_ready.
- acc_o, output, ACC_W: signed frame sum, registered.
- frame_o, output, FRM_W: index of the frame in acc_o, registered.

## Operation
- Term conversion: term = sign_extend(p_i, ACC_W) + p_i[31].
  - This adds 1 when the MSB is set, mapping ~x to -x.
  - p_i = 0 gives term 0.
- State: acc (ACC_W), cnt (0..LEN-1), result register (acc_o, frame_o, out_valid), frm counter.
- final = (cnt == LEN-1).
- in_ready = ~clear & ~(final & out_valid & ~out_ready). This is combinational from registers and inputs only. It never depends on p_i or in_valid.
- Accepted beat with ~final: acc <= acc + term; cnt <= cnt + 1.
- Accepted beat with final:
  - acc_o <= acc + term; frame_o <= frm; out_valid <= 1.
  - acc <= 0; cnt <= 0; frm <= frm + 1, wrapping modulo 2^FRM_W.
- Result handshake: out_valid & out_ready with no final beat accepted in the same cycle gives out_valid <= 0. acc_o and frame_o hold their last values.
- Simultaneous consume and final beat: the new result loads and out_valid stays 1. No bubble, no loss.
- clear = 1:
  - acc <= 0 and cnt <= 0. in_ready = 0, so no beat is taken.
  - frm is unchanged. A pending result is unaffected and is still delivered.
- Overflow is impossible within the LEN constraint. No saturation logic.
- Reset (rst_n = 0, asynchronous): acc, cnt, frm, acc_o and frame_o go to 0; out_valid goes to 0.
  - in_ready reads 1 while rst_n is high, out of reset, with clear low.
  - A partial frame and any pending result are discarded.

## Timing
- Latency: acc_o and out_valid update on the clock edge that accepts the final beat. They are visible in the following cycle.
- Throughput: one product per cycle, sustained, while out_ready is high or out_valid is low.
- Stall: in_ready drops only when the final beat of frame k+1 is offered while result k is still unconsumed. It rises in the cycle where out_ready = 1.
- out_valid, acc_o and frame_o stay stable while out_valid & ~out_ready.
- Non-final beats are always accepted, unless clear is high.

## Test plan
All scenarios use LEN = 4.
- Four beats of 32'h0000_1AAA, out_ready = 1 -> one cycle after beat 4: acc_o = 40'h00_0000_6AA8, frame_o = 0, out_valid high for 1 cycle.
- Beats 32'h0000_1AAA, 32'hFFFF_E555, 32'h0000_1AAA, 32'hFFFF_E555 -> acc_o = 0.
  - Without sign correction this would be 40'hFF_FFFF_FFFE; flag that value as a failure.
- out_ready = 0 with 8 beats streamed back-to-back:
  - Result 0 is held.
  - Beats 5-7 are accepted.
  - in_ready = 0 while beat 8 is offered.
  - Raise out_ready for 1 cycle -> beat 8 accepted that cycle; next cycle frame_o = 1 and out_valid = 1.
- Final beat of frame 1 coincides with out_ready = 1 on result 0 -> out_valid stays continuously high and frame_o steps 0 -> 1.
- rst_n pulsed low after 2 beats of 32'h0000_0100 -> all outputs 0 immediately.
  - A following frame of 4 x 32'h0000_0100 gives acc_o = 40'h00_0000_0400 and frame_o = 0.
- clear pulsed after 3 beats while result 0 is pending -> result 0 is delivered unchanged.
  - The next 4 beats of 32'h0000_0010 give acc_o = 40'h00_0000_0040 with frame_o = 1.

Source files
------------

// File: rtl/approx_prod_acc_if.sv
// rtl/approx_prod_acc_if.sv - product stream in / frame sum out handshake bundle
interface approx_prod_acc_if #(
  parameter int ACC_W = 40,
  parameter int FRM_W = 8
);
  // Product beat stream from the approximate multiplier
  logic                    in_valid;
  logic                    in_ready;
  logic [31:0]             p_i;

  // Registered frame-sum result
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] acc_o;
  logic [FRM_W-1:0]        frame_o;

  // Producer of products and consumer of results
  modport master (
    output in_valid,
    output p_i,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  acc_o,
    input  frame_o
  );

  // The accumulator itself
  modport slave (
    input  in_valid,
    input  p_i,
    input  out_ready,
    output in_ready,
    output out_valid,
    output acc_o,
    output frame_o
  );
endinterface

// File: rtl/approx_prod_acc.sv
// rtl/approx_prod_acc.sv - sums LEN ones'-complement products into registered frame results
module approx_prod_acc #(
  parameter int LEN   = 16,
  parameter int ACC_W = 40,
  parameter int FRM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  approx_prod_acc_if.slave bus
);

  localparam int CNT_W = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [FRM_W-1:0] FRM_ONE  = FRM_W'(1);

  // Running partial sum and beat position within the current frame
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRM_W-1:0]        frm_q, frm_d;

  // Result register presented downstream
  logic signed [ACC_W-1:0] res_q, res_d;
  logic [FRM_W-1:0]        res_frm_q, res_frm_d;
  logic                    valid_q, valid_d;

  logic                    final_beat;
  logic                    stall;
  logic                    ready;
  logic                    accept;
  logic                    consume;
  logic signed [ACC_W-1:0] term;
  logic signed [ACC_W-1:0] sum;

  // A negative product arrives as ~x; sign-extending and adding its MSB
  // yields -x, while an all-zero product stays zero.
  assign term = $signed({{(ACC_W-32){bus.p_i[31]}}, bus.p_i})
              + $signed({{(ACC_W-1){1'b0}}, bus.p_i[31]});
  assign sum  = acc_q + term;

  // Only the closing beat of a frame can be blocked, and only while the
  // previous result is still sitting unconsumed in the result register.
  assign final_beat = (cnt_q == CNT_LAST);
  assign stall      = final_beat & valid_q & ~bus.out_ready;
  assign ready      = ~clear & ~stall;
  assign accept     = bus.in_valid & ready;
  assign consume    = valid_q & bus.out_ready;

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid_q;
  assign bus.acc_o     = res_q;
  assign bus.frame_o   = res_frm_q;

  // Accumulate accepted beats; the closing beat hands the sum to the result register
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    frm_d = frm_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (final_beat) begin
        acc_d = '0;
        cnt_d = '0;
        frm_d = frm_q + FRM_ONE;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // Result register: a new load wins over a same-cycle consume, so there is no bubble
  always_comb begin
    res_d     = res_q;
    res_frm_d = res_frm_q;
    valid_d   = valid_q;
    if (consume) begin
      valid_d = 1'b0;
    end
    if (accept && final_beat) begin
      res_d     = sum;
      res_frm_d = frm_q;
      valid_d   = 1'b1;
    end
  end

  // State registers with asynchronous reset discarding partial and pending work
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      frm_q     <= '0;
      res_q     <= '0;
      res_frm_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      frm_q     <= frm_d;
      res_q     <= res_d;
      res_frm_q <= res_frm_d;
      valid_q   <= valid_d;
    end
  end

endmodule
